// File: rtl/nibble_add_seq.sv
// nibble_add_seq: multi-cycle WIDTH-bit add/subtract sequencer.
// One nibble per cycle is fed LSB-first through an external 4-bit adder
// slice; this block owns the operand/carry registers, the nibble index and
// the start/busy/done handshake. The carry ripples between nibbles through
// cr_reg, so the slice path stays register -> slice -> register each cycle.
module nibble_add_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf,
    output logic [3:0]       slice_a,
    output logic [3:0]       slice_b,
    output logic             slice_ci,
    input  logic [3:0]       slice_sum,
    input  logic             slice_co
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = $clog2(NIB) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_reg;
    logic [WIDTH-1:0] ra_reg;
    logic [WIDTH-1:0] rb_reg;
    logic             cr_reg;
    logic [IW-1:0]    idx_reg;
    logic             co_reg;
    logic             ovf_reg;

    logic [3:0] ra_nib [NIB];
    logic [3:0] rb_nib [NIB];
    logic [3:0] sum_nib_reg [NIB];

    logic accept;
    logic running;
    logic last_nib;

    // A new operation is taken only when not already running.
    assign accept   = start && (state_reg != RUN);
    assign running  = (state_reg == RUN);
    assign last_nib = running && (idx_reg == IW'(NIB - 1));

    // Split the operand registers into nibbles for the slice mux.
    generate
        for (genvar gi = 0; gi < NIB; gi++) begin : g_split
            assign ra_nib[gi] = ra_reg[4*gi +: 4];
            assign rb_nib[gi] = rb_reg[4*gi +: 4];
        end
    endgenerate

    // Control state, operand latching, carry ripple and final flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            ra_reg    <= '0;
            rb_reg    <= '0;
            cr_reg    <= 1'b0;
            idx_reg   <= '0;
            co_reg    <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        // Subtraction is a + ~b + 1, so b is inverted here
                        // and the incoming carry is forced high.
                        ra_reg    <= a;
                        rb_reg    <= sub ? ~b : b;
                        cr_reg    <= sub ? 1'b1 : ci;
                        idx_reg   <= '0;
                        co_reg    <= 1'b0;
                        ovf_reg   <= 1'b0;
                        state_reg <= RUN;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                RUN: begin
                    cr_reg  <= slice_co;
                    idx_reg <= idx_reg + 1'b1;
                    if (last_nib) begin
                        // Overflow: same operand signs, result sign differs.
                        co_reg    <= slice_co;
                        ovf_reg   <= (ra_reg[WIDTH-1] == rb_reg[WIDTH-1]) &&
                                     (slice_sum[3] != ra_reg[WIDTH-1]);
                        state_reg <= DONE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Per-nibble result registers: cleared on accept, written when selected.
    generate
        for (genvar gi = 0; gi < NIB; gi++) begin : g_sum
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sum_nib_reg[gi] <= 4'h0;
                end else if (accept) begin
                    sum_nib_reg[gi] <= 4'h0;
                end else if (running && (idx_reg == IW'(gi))) begin
                    sum_nib_reg[gi] <= slice_sum;
                end
            end
            assign sum[4*gi +: 4] = sum_nib_reg[gi];
        end
    endgenerate

    // Drive the current nibble and carry to the slice; quiet outside RUN.
    always_comb begin
        slice_a  = 4'h0;
        slice_b  = 4'h0;
        slice_ci = 1'b0;
        if (running) begin
            slice_ci = cr_reg;
            for (int i = 0; i < NIB; i++) begin
                if (idx_reg == IW'(i)) begin
                    slice_a = ra_nib[i];
                    slice_b = rb_nib[i];
                end
            end
        end
    end

    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);
    assign co   = co_reg;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_nibble_add_seq.sv
// Directed testbench for nibble_add_seq (WIDTH=32) with a behavioural
// 4-bit adder slice wired to the slice_* ports.
module tb_nibble_add_seq;

    localparam int WIDTH = 32;
    localparam int NIB   = WIDTH / 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             ovf;
    logic [3:0]       slice_a;
    logic [3:0]       slice_b;
    logic             slice_ci;
    logic [3:0]       slice_sum;
    logic             slice_co;

    int tests;
    int fails;

    nibble_add_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .co        (co),
        .ovf       (ovf),
        .slice_a   (slice_a),
        .slice_b   (slice_b),
        .slice_ci  (slice_ci),
        .slice_sum (slice_sum),
        .slice_co  (slice_co)
    );

    // External adder slice model.
    assign {slice_co, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} + {4'b0, slice_ci};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one start pulse; returns at the negedge of the first busy cycle.
    task automatic launch(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic civ, input logic subv);
        @(negedge clk);
        a = av; b = bv; ci = civ; sub = subv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; ci = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            tests++;
            if ({busy, done, sum, co, ovf, slice_a, slice_b, slice_ci} !== '0) begin
                fails++;
                $display("FAIL reset_idle cyc=%0d got busy=%b done=%b sum=%h co=%b ovf=%b sa=%h sb=%h sci=%b want all 0",
                         k, busy, done, sum, co, ovf, slice_a, slice_b, slice_ci);
            end
        end
        $display("[TB] reset: idle outputs checked for 5 cycles");
    endtask

    // 0x0000FFFF + 1: checks busy window, done timing and carry ripple.
    task automatic test_timing();
        logic exp_ci;
        launch(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        for (int k = 0; k < NIB; k++) begin
            exp_ci = (k >= 1 && k <= 4);
            tests++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                fails++;
                $display("FAIL timing_busy cyc=%0d got busy=%b done=%b want busy=1 done=0", k + 1, busy, done);
            end
            tests++;
            if (slice_ci !== exp_ci) begin
                fails++;
                $display("FAIL timing_slice_ci nib=%0d got %b want %b", k, slice_ci, exp_ci);
            end
            if (k == 0) begin
                tests++;
                if (slice_a !== 4'hF || slice_b !== 4'h1) begin
                    fails++;
                    $display("FAIL timing_slice_nib0 got a=%h b=%h want a=f b=1", slice_a, slice_b);
                end
            end
            @(negedge clk);
        end
        tests++;
        if (done !== 1'b1 || busy !== 1'b0 || sum !== 32'h0001_0000 || co !== 1'b0 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL timing_done got done=%b busy=%b sum=%h co=%b ovf=%b want done=1 busy=0 sum=00010000 co=0 ovf=0",
                     done, busy, sum, co, ovf);
        end
        tests++;
        if (slice_a !== 4'h0 || slice_b !== 4'h0 || slice_ci !== 1'b0) begin
            fails++;
            $display("FAIL timing_slice_quiet got a=%h b=%h ci=%b want 0", slice_a, slice_b, slice_ci);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || busy !== 1'b0 || sum !== 32'h0001_0000) begin
            fails++;
            $display("FAIL timing_hold got done=%b busy=%b sum=%h want done=0 busy=0 sum=00010000", done, busy, sum);
        end
        $display("[TB] timing: 0000ffff+00000001 -> sum=%h co=%b ovf=%b", sum, co, ovf);
    endtask

    task automatic test_arith();
        logic [WIDTH-1:0] va   [6] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0005,
                                       32'h0000_0007, 32'h8000_0000, 32'h1234_5678};
        logic [WIDTH-1:0] vb   [6] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0007,
                                       32'h0000_0005, 32'h0000_0001, 32'h1111_1111};
        logic             vci  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic             vsub [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [WIDTH-1:0] es   [6] = '{32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFE,
                                       32'h0000_0002, 32'h7FFF_FFFF, 32'h2345_6789};
        logic             eco  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic             eovf [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int v = 0; v < 6; v++) begin
            launch(va[v], vb[v], vci[v], vsub[v]);
            repeat (NIB) @(negedge clk);
            tests++;
            if (done !== 1'b1 || sum !== es[v] || co !== eco[v] || ovf !== eovf[v]) begin
                fails++;
                $display("FAIL arith_%0d got done=%b sum=%h co=%b ovf=%b want done=1 sum=%h co=%b ovf=%b",
                         v, done, sum, co, ovf, es[v], eco[v], eovf[v]);
            end
            $display("[TB] arith %0d: a=%h b=%h ci=%b sub=%b -> sum=%h co=%b ovf=%b",
                     v, va[v], vb[v], vci[v], vsub[v], sum, co, ovf);
        end
    endtask

    // start pulses during RUN must not disturb the running operation.
    task automatic test_ignore_start();
        launch(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        for (int k = 0; k < NIB; k++) begin
            if (k == 2 || k == 4) begin
                start = 1'b1; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; sub = 1'b1; ci = 1'b1;
            end else begin
                start = 1'b0;
            end
            tests++;
            if (busy !== 1'b1) begin
                fails++;
                $display("FAIL ignore_busy cyc=%0d got busy=%b want 1", k + 1, busy);
            end
            @(negedge clk);
        end
        start = 1'b0;
        tests++;
        if (done !== 1'b1 || sum !== 32'h2345_6789 || co !== 1'b0 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL ignore_result got done=%b sum=%h co=%b ovf=%b want done=1 sum=23456789 co=0 ovf=0",
                     done, sum, co, ovf);
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL ignore_after got busy=%b done=%b want 0 0", busy, done);
        end
        $display("[TB] ignore_start: sum=%h", sum);
    endtask

    // start held in the done cycle is accepted immediately.
    task automatic test_back_to_back();
        launch(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0);
        repeat (NIB) @(negedge clk);
        a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; ci = 1'b0; sub = 1'b0; start = 1'b1;
        tests++;
        if (done !== 1'b1 || sum !== 32'h0000_0007) begin
            fails++;
            $display("FAIL b2b_first got done=%b sum=%h want done=1 sum=00000007", done, sum);
        end
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL b2b_accept got busy=%b done=%b want busy=1 done=0", busy, done);
        end
        repeat (NIB) @(negedge clk);
        tests++;
        if (done !== 1'b1 || sum !== 32'hFFFF_FFFE || co !== 1'b1 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL b2b_second got done=%b sum=%h co=%b ovf=%b want done=1 sum=fffffffe co=1 ovf=0",
                     done, sum, co, ovf);
        end
        $display("[TB] back_to_back: second sum=%h co=%b", sum, co);
        @(negedge clk);
    endtask

    // Asynchronous reset in RUN cycle 4, then a fresh operation.
    task automatic test_reset_mid_run();
        launch(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if ({busy, done, sum, co, ovf, slice_a, slice_b, slice_ci} !== '0) begin
            fails++;
            $display("FAIL rst_mid got busy=%b done=%b sum=%h co=%b ovf=%b sa=%h sb=%h sci=%b want all 0",
                     busy, done, sum, co, ovf, slice_a, slice_b, slice_ci);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL rst_idle got busy=%b done=%b want 0 0", busy, done);
        end
        launch(32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 1'b1);
        repeat (NIB) @(negedge clk);
        tests++;
        if (done !== 1'b1 || sum !== 32'h0E0E_0E0E || co !== 1'b1 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL rst_fresh got done=%b sum=%h co=%b ovf=%b want done=1 sum=0e0e0e0e co=1 ovf=0",
                     done, sum, co, ovf);
        end
        $display("[TB] reset_mid_run: fresh sum=%h co=%b", sum, co);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_timing();
        test_arith();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
